seq_scan_ctrl: RTL and testbench
================================

# seq_scan_ctrl

Byte-fed scan controller for the serial pattern detector. Accepts bytes over a valid/ready handshake and serialises each MSB-first into a programmable Moore detector. Counts overlapping pattern matches and stops the scan once a programmed match limit is reached. It is the sequencing and configuration layer that drives the detector's DIN from a parallel source.

## Interface
Parameters:
- PAT_W, 4: pattern length in bits (2..8).
- CNT_W, 8: width of the match counter and of MATCH_LIMIT.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  synchronous, active-low reset (sampled on CLK; 0 = reset).
- START  in  1  1-cycle request: latch PATTERN/MATCH_LIMIT and begin a scan.
- ABORT  in  1  return to IDLE from any state; has priority over START.
- PATTERN  in  PAT_W  pattern to detect; bit PAT_W-1 is the oldest bit.
- MATCH_LIMIT  in  CNT_W  match count that ends the scan; 0 = unlimited.
- IN_VALID  in  1  IN_DATA is valid.
- IN_DATA  in  8  byte to scan, shifted MSB first.
- IN_READY  out  1  controller accepts a byte this cycle.
- HIT  out  1  high for one cycle per detected match.
- MATCH_COUNT  out  CNT_W  matches since last START; saturates at all-ones.
- BUSY  out  1  high in LOAD and SHIFT.
- DONE  out  1  high in DONE state.

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - IN_READY=0.
  - On START, latch PATTERN and MATCH_LIMIT.
  - Clear MATCH_COUNT, history and fill counter, then go to LOAD.
- LOAD:
  - IN_READY=1.
  - On IN_VALID&IN_READY, capture IN_DATA, set bit index to 7, then go to SHIFT.
  - Without IN_VALID, wait indefinitely.
- SHIFT:
  - Each cycle, shift bit[index] into the PAT_W-bit history and decrement the index.
  - After index 0 shifts, go to LOAD.
  - IN_READY=0.
- Match rule:
  - A match occurs when the updated history equals the latched pattern and at least PAT_W bits have been shifted since START.
  - The fill counter saturates at PAT_W.
  - Matches may overlap. History persists across byte boundaries.
- Limit:
  - If MATCH_LIMIT≠0 and the match brings MATCH_COUNT to MATCH_LIMIT, go to DONE on that same edge.
  - Unshifted bits of the current byte are discarded.
  - MATCH_LIMIT=0 never ends the scan.
- DONE:
  - DONE=1, IN_READY=0.
  - START restarts exactly as from IDLE. ABORT goes to IDLE.
- START in LOAD or SHIFT is ignored.
- ABORT in any state goes to IDLE. MATCH_COUNT is held, not cleared.
- Reset: state=IDLE. IN_READY, HIT, BUSY and DONE are 0. MATCH_COUNT, history, fill and index are 0.

## Timing
- HIT and MATCH_COUNT update on the same edge that shifts the matching bit in, so HIT is visible in the following cycle (Moore, registered).
- Throughput: 9 cycles per byte (1 LOAD + 8 SHIFT) under continuous IN_VALID.
- Byte accept to first HIT possible: the bit shifted on the first SHIFT edge can match. Earliest match is PAT_W bits after START.
- Limit hit: DONE rises in the same cycle as the final HIT. BUSY falls in that cycle.
- Reset asserted mid-SHIFT: next cycle is IDLE. The in-flight byte is dropped and no HIT is produced.
- ABORT and START in the same cycle: ABORT wins, and the next state is IDLE.

## Structure
- Package seq_scan_pkg: state enum (IDLE, LOAD, SHIFT, DONE), default PAT_W/CNT_W constants.
- Sub-module pattern_det:
  - Holds the history shift register, fill counter and compare logic.
  - Inputs: CLK, RESET, CLR, SHIFT_EN, BIT_IN, PATTERN.
  - Output: MATCH (combinational on next history).
  - The top level holds the FSM, byte register, index, counter and limit check.

## Test plan
- PATTERN=4'b1011, LIMIT=0, byte 0xB6:
  - Two HIT pulses, after shift bits 4 and 7 (overlap).
  - MATCH_COUNT=2. Returns to LOAD after 8 SHIFT cycles.
- Cross-byte: PATTERN=4'b1011, bytes 0x01 then 0x60:
  - Exactly one HIT, on bit 3 of the second byte.
  - MATCH_COUNT=1.
- Limit: PATTERN=4'b1011, LIMIT=1, byte 0xB6:
  - DONE after bit 4. Bits 5–8 are not shifted.
  - MATCH_COUNT=1, IN_READY=0. A second byte is not accepted.
- Fill guard: PATTERN=4'b0000, byte 0x00 after START:
  - No HIT on bits 1–3. HITs on bits 4–8.
  - MATCH_COUNT=5.
- Backpressure/abort: IN_VALID low 5 cycles in LOAD keeps IN_READY=1 and BUSY=1. ABORT mid-SHIFT puts the controller in IDLE the next cycle and holds MATCH_COUNT.
- Reset mid-SHIFT (RESET=0 one cycle):
  - All outputs return to 0, state is IDLE.
  - A subsequent START with 0xB6 reproduces the 2-match result.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared definitions for the byte-fed scan controller.
//   scan_state_e : controller state encoding (IDLE, LOAD, SHIFT, DONE)
//   DEF_PAT_W    : default pattern length in bits
//   DEF_CNT_W    : default width of the match counter and match limit
package seq_scan_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Control, byte-stream and status bundle of the scan controller.
//   master : the side that issues START/ABORT, the pattern setup and the byte stream
//   slave  : the controller; returns IN_READY, HIT, MATCH_COUNT, BUSY and DONE
interface seq_scan_ctrl_if
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] match_limit;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             hit;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, match_limit, in_valid, in_data,
    input  in_ready, hit, match_count, busy, done
  );

  modport slave (
    input  start, abort, pattern, match_limit, in_valid, in_data,
    output in_ready, hit, match_count, busy, done
  );

endinterface

// File: rtl/seq_scan_ctrl_pattern_det.sv
// Moore-style serial pattern detector core.
//   clk      : rising-edge clock
//   reset    : synchronous active-low reset
//   clr      : clear history and fill counter (start of a new scan)
//   shift_en : shift bit_in into the history this cycle
//   bit_in   : serial input bit
//   pattern  : pattern to compare against, bit PAT_W-1 is the oldest bit
//   match    : combinational, true when the history after this shift equals the
//              pattern and at least PAT_W bits have been shifted since clr
module pattern_det #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_r;
  logic [PAT_W-1:0]  hist_next_s;
  logic [FILL_W-1:0] fill_r;
  logic              full_s;

  // Next history value and match decision for the bit being shifted this cycle
  always_comb begin
    hist_next_s = {hist_r[PAT_W-2:0], bit_in};
    // fill_r counts bits already shifted; this shift makes it PAT_W or more
    full_s      = (fill_r >= FILL_W'(PAT_W - 1));
    if (shift_en && full_s && (hist_next_s == pattern)) begin
      match = 1'b1;
    end else begin
      match = 1'b0;
    end
  end

  // History shift register and saturating fill counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else if (clr) begin
      hist_r <= {PAT_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else if (shift_en) begin
      hist_r <= hist_next_s;
      if (fill_r != FILL_W'(PAT_W)) begin
        fill_r <= fill_r + {{(FILL_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Byte-fed scan controller: accepts bytes on a valid/ready handshake, serialises
// each one MSB-first into pattern_det, counts (overlapping) matches and stops
// once a programmed non-zero match limit is reached.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : seq_scan_ctrl_if.slave -- start/abort/pattern/match_limit,
//           in_valid/in_data/in_ready, hit, match_count, busy, done
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_scan_ctrl_if.slave bus
);

  scan_state_e      state_r;
  logic [PAT_W-1:0] pattern_r;
  logic [CNT_W-1:0] limit_r;
  logic [CNT_W-1:0] count_r;
  logic [7:0]       byte_r;
  logic [2:0]       idx_r;
  logic             in_ready_r;
  logic             hit_r;
  logic             busy_r;
  logic             done_r;

  logic             det_clr_s;
  logic             det_shift_s;
  logic             det_bit_s;
  logic             det_match_s;
  logic [CNT_W-1:0] count_inc_s;
  logic             limit_hit_s;

  // Detector controls, saturating count increment and limit check for this cycle
  always_comb begin
    det_bit_s = byte_r[idx_r];
    if (!bus.abort && bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
      det_clr_s = 1'b1;
    end else begin
      det_clr_s = 1'b0;
    end
    if (!bus.abort && (state_r == ST_SHIFT)) begin
      det_shift_s = 1'b1;
    end else begin
      det_shift_s = 1'b0;
    end
    if (count_r == {CNT_W{1'b1}}) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    // A zero limit means the scan never ends on its own
    if ((limit_r != {CNT_W{1'b0}}) && (count_inc_s == limit_r)) begin
      limit_hit_s = 1'b1;
    end else begin
      limit_hit_s = 1'b0;
    end
  end

  pattern_det #(
    .PAT_W (PAT_W)
  ) u_det (
    .clk      (clk),
    .reset    (reset),
    .clr      (det_clr_s),
    .shift_en (det_shift_s),
    .bit_in   (det_bit_s),
    .pattern  (pattern_r),
    .match    (det_match_s)
  );

  // Scan FSM with registered status outputs, byte register, index and match counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      pattern_r  <= {PAT_W{1'b0}};
      limit_r    <= {CNT_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      byte_r     <= 8'h00;
      idx_r      <= 3'd0;
      in_ready_r <= 1'b0;
      hit_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      hit_r <= 1'b0;
      if (bus.abort) begin
        // Abort wins over everything; the match count is kept for inspection
        state_r    <= ST_IDLE;
        in_ready_r <= 1'b0;
        busy_r     <= 1'b0;
        done_r     <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE, ST_DONE: begin
            if (bus.start) begin
              pattern_r  <= bus.pattern;
              limit_r    <= bus.match_limit;
              count_r    <= {CNT_W{1'b0}};
              state_r    <= ST_LOAD;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
              done_r     <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (bus.in_valid && in_ready_r) begin
              byte_r     <= bus.in_data;
              idx_r      <= 3'd7;
              state_r    <= ST_SHIFT;
              in_ready_r <= 1'b0;
            end
          end
          ST_SHIFT: begin
            if (det_match_s) begin
              hit_r   <= 1'b1;
              count_r <= count_inc_s;
            end
            if (det_match_s && limit_hit_s) begin
              // Remaining bits of the current byte are dropped
              state_r    <= ST_DONE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else if (idx_r == 3'd0) begin
              state_r    <= ST_LOAD;
              in_ready_r <= 1'b1;
            end else begin
              idx_r <= idx_r - 3'd1;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.hit         = hit_r;
  assign bus.match_count = count_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: vector table of scans plus hand-written corner sequences.
module tb_seq_scan_ctrl;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  seq_scan_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic             hit;
    logic [CNT_W-1:0] cnt;
    logic             done;
  } exp_t;

  typedef struct {
    logic [PAT_W-1:0] pat;
    logic [CNT_W-1:0] lim;
    int               nbytes;
    logic [7:0]       b0;
    logic [7:0]       b1;
    int               exp_cnt;
    logic             exp_done;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [PAT_W-1:0] m_pat;
  logic [CNT_W-1:0] m_lim;
  logic [CNT_W-1:0] m_cnt;
  logic [PAT_W-1:0] m_win;
  int               m_nbits;
  logic             m_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] lim);
    bus.pattern     = pat;
    bus.match_limit = lim;
    bus.start       = 1'b1;
    tick();
    bus.start = 1'b0;
    m_pat   = pat;
    m_lim   = lim;
    m_cnt   = '0;
    m_win   = '0;
    m_nbits = 0;
    m_done  = 1'b0;
    check("start_ready", bus.in_ready, 1);
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    check("start_count", bus.match_count, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   waited;
    exp_t e;
    waited       = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("accept_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    check("shift_ready", bus.in_ready, 0);
    for (int i = 7; i >= 0; i--) begin
      if (!m_done) begin
        m_win = {m_win[PAT_W-2:0], b[i]};
        if (m_nbits < PAT_W) m_nbits++;
        e.hit = (m_nbits == PAT_W) && (m_win == m_pat);
        if (e.hit && (m_cnt != {CNT_W{1'b1}})) m_cnt++;
        if (e.hit && (m_lim != 0) && (m_cnt == m_lim)) m_done = 1'b1;
        e.cnt  = m_cnt;
        e.done = m_done;
        sb_q.push_back(e);
      end
    end
    while (sb_q.size() > 0) begin
      tick();
      e = sb_q.pop_front();
      check("bit_hit", bus.hit, e.hit);
      check("bit_count", bus.match_count, e.cnt);
      check("bit_done", bus.done, e.done);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.pattern     = '0;
    bus.match_limit = '0;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    reset           = 1'b0;

    vecs[0] = '{4'b1011, 8'd0, 1, 8'hB6, 8'h00, 2,  1'b0};
    vecs[1] = '{4'b1011, 8'd0, 2, 8'h01, 8'h60, 1,  1'b0};
    vecs[2] = '{4'b1011, 8'd1, 1, 8'hB6, 8'h00, 1,  1'b1};
    vecs[3] = '{4'b0000, 8'd0, 1, 8'h00, 8'h00, 5,  1'b0};
    vecs[4] = '{4'b1011, 8'd2, 2, 8'hB6, 8'hB6, 2,  1'b1};
    vecs[5] = '{4'b1111, 8'd0, 2, 8'hFF, 8'hFF, 13, 1'b0};

    tick();
    tick();
    check("rst_ready", bus.in_ready, 0);
    check("rst_hit", bus.hit, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_count", bus.match_count, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", bus.busy, 0);

    for (int v = 0; v < 6; v++) begin
      do_start(vecs[v].pat, vecs[v].lim);
      send_byte(vecs[v].b0);
      if (vecs[v].nbytes > 1 && !m_done) send_byte(vecs[v].b1);
      check("vec_count", bus.match_count, vecs[v].exp_cnt);
      check("vec_done", bus.done, vecs[v].exp_done);
      check("vec_busy", bus.busy, !vecs[v].exp_done);
      check("vec_ready", bus.in_ready, !vecs[v].exp_done);
      if (vecs[v].exp_done) begin
        // A further byte must not be accepted once the limit stopped the scan
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        check("done_ready", bus.in_ready, 0);
        check("done_count", bus.match_count, vecs[v].exp_cnt);
        check("done_hold", bus.done, 1);
      end else begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_ready", bus.in_ready, 0);
        check("abort_count", bus.match_count, vecs[v].exp_cnt);
      end
    end

    // Backpressure in LOAD, then ABORT together with START in the middle of SHIFT
    do_start(4'b1011, 8'd0);
    repeat (5) begin
      tick();
      check("bp_ready", bus.in_ready, 1);
      check("bp_busy", bus.busy, 1);
    end
    bus.in_data  = 8'hB6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    check("mid_count", bus.match_count, 1);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("ab_busy", bus.busy, 0);
    check("ab_ready", bus.in_ready, 0);
    check("ab_done", bus.done, 0);
    check("ab_hit", bus.hit, 0);
    check("ab_count", bus.match_count, 1);
    tick();
    check("ab_idle_busy", bus.busy, 0);

    // Reset for one cycle in the middle of SHIFT
    do_start(4'b1011, 8'd0);
    bus.in_data  = 8'hB6;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rs_hit", bus.hit, 0);
    check("rs_count", bus.match_count, 0);
    check("rs_busy", bus.busy, 0);
    check("rs_done", bus.done, 0);
    check("rs_ready", bus.in_ready, 0);
    tick();
    check("rs_idle_hit", bus.hit, 0);
    check("rs_idle_busy", bus.busy, 0);
    do_start(4'b1011, 8'd0);
    send_byte(8'hB6);
    check("rs_rerun_count", bus.match_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
